// File: rtl/test_scoreboard_pkg.sv
// Purpose: shared types and constants for the multi-channel test scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package test_scoreboard_pkg;

    // Overall scoreboard lifecycle; DONE and TIMEOUT hold until reset.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam int ERR_W  = 16;  // width of the saturating mismatch counter
    localparam int CHAN_W = 4;   // width of the captured channel index

endpackage

// File: rtl/test_scoreboard_fifo.sv
// Purpose: per-channel expected-entry FIFO holding a message and its don't-care mask.
// Latency: an entry pushed at edge N is at the head (empty=0) after edge N; no bypass.
// Backpressure: full/empty come from registered pointers only; caller gates push/pop.
// Ports: clk, reset (sync, active-high), push/push_msg/push_mask, pop,
//        full, empty, head_msg/head_mask (oldest entry).
module test_scoreboard_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_msg,
    input  logic [WIDTH-1:0] push_mask,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_msg,
    output logic [WIDTH-1:0] head_mask
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] msg_mem  [DEPTH];
    logic [WIDTH-1:0] mask_mem [DEPTH];

    // One extra pointer bit distinguishes full from empty when addresses match.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: contents are only observed behind a valid pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            msg_mem[wr_ptr[AW-1:0]]  <= push_msg;
            mask_mem[wr_ptr[AW-1:0]] <= push_mask;
        end
    end

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_msg  = msg_mem[rd_ptr[AW-1:0]];
    assign head_mask = mask_mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/test_scoreboard.sv
// Purpose: multi-channel in-order scoreboard with masked compare, timeout, drain/done FSM,
//          saturating error count and first-error capture.
// Latency: error outputs 1 cycle after DUT fire; done/timed_out/pass 1 cycle after condition.
// Backpressure: ref_rdy = !full, dut_rdy = !empty, both from registered FIFO state only.
// Ports: clk, reset (sync, active-high); ref_val/ref_rdy/ref_msg/ref_mask and
//        dut_val/dut_rdy/dut_msg per channel (channel c at [c*WIDTH +: WIDTH]);
//        finish pulse in; done, timed_out, pass, err_count, err_chan, err_dut, err_ref out.
// Optional: define TEST_SCOREBOARD_DISPLAY_EN for simulation messages on mismatch,
//           timeout and completion; hardware behaviour is unchanged.
module test_scoreboard
    import test_scoreboard_pkg::*;
#(
    parameter int NCHANNELS = 1,
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int TIMEOUT   = 10000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NCHANNELS-1:0]      ref_val,
    output logic [NCHANNELS-1:0]      ref_rdy,
    input  logic [NCHANNELS*WIDTH-1:0] ref_msg,
    input  logic [NCHANNELS*WIDTH-1:0] ref_mask,
    input  logic [NCHANNELS-1:0]      dut_val,
    output logic [NCHANNELS-1:0]      dut_rdy,
    input  logic [NCHANNELS*WIDTH-1:0] dut_msg,
    input  logic                      finish,
    output logic                      done,
    output logic                      timed_out,
    output logic                      pass,
    output logic [ERR_W-1:0]          err_count,
    output logic [CHAN_W-1:0]         err_chan,
    output logic [WIDTH-1:0]          err_dut,
    output logic [WIDTH-1:0]          err_ref
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [NCHANNELS-1:0] full;
    logic [NCHANNELS-1:0] empty;
    logic [NCHANNELS-1:0] mismatch;
    logic [WIDTH-1:0]     head_msg  [NCHANNELS];
    logic [WIDTH-1:0]     head_mask [NCHANNELS];

    assign ref_rdy = ~full;
    assign dut_rdy = ~empty;

    for (genvar c = 0; c < NCHANNELS; c++) begin : g_chan
        test_scoreboard_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (ref_val[c] & ~full[c]),
            .push_msg  (ref_msg[c*WIDTH +: WIDTH]),
            .push_mask (ref_mask[c*WIDTH +: WIDTH]),
            .pop       (dut_val[c] & ~empty[c]),
            .full      (full[c]),
            .empty     (empty[c]),
            .head_msg  (head_msg[c]),
            .head_mask (head_mask[c])
        );

        // Masked bits (mask=1) never contribute to a mismatch.
        assign mismatch[c] = dut_val[c] & ~empty[c] &
                             (|((dut_msg[c*WIDTH +: WIDTH] ^ head_msg[c]) & ~head_mask[c]));
    end

    // ---------------- error accounting ----------------
    logic [ERR_W:0]      mm_cnt;
    logic [ERR_W:0]      err_sum;
    logic [ERR_W-1:0]    err_next;
    logic [CHAN_W-1:0]   cap_chan;
    logic [WIDTH-1:0]    cap_dut;
    logic [WIDTH-1:0]    cap_ref;

    // Walk channels high to low so the lowest mismatching channel is the one captured.
    always_comb begin
        mm_cnt   = '0;
        cap_chan = '0;
        cap_dut  = '0;
        cap_ref  = '0;
        for (int c = NCHANNELS - 1; c >= 0; c--) begin
            if (mismatch[c]) begin
                mm_cnt   = mm_cnt + (ERR_W+1)'(1);
                cap_chan = CHAN_W'(c);
                cap_dut  = dut_msg[c*WIDTH +: WIDTH];
                cap_ref  = head_msg[c];
            end
        end
        err_sum  = {1'b0, err_count} + mm_cnt;
        err_next = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
            err_chan  <= '0;
            err_dut   <= '0;
            err_ref   <= '0;
        end else begin
            err_count <= err_next;
            if (err_count == '0 && |mismatch) begin
                err_chan <= cap_chan;
                err_dut  <= cap_dut;
                err_ref  <= cap_ref;
            end
        end
    end

    // ---------------- cycle counter and FSM ----------------
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cycles;
    logic          timeout_hit;

    assign timeout_hit = (cycles == CW'(TIMEOUT));

    // Saturates at TIMEOUT and freezes once DONE so it records completion time.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycles <= '0;
        end else if (state != ST_DONE && !timeout_hit) begin
            cycles <= cycles + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nxt;
    end

    // Timeout is checked first so it wins over finish or drain-complete in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (timeout_hit)  state_nxt = ST_TIMEOUT;
                else if (finish)  state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (timeout_hit)  state_nxt = ST_TIMEOUT;
                else if (&empty)  state_nxt = ST_DONE;
            end
            default: state_nxt = state;
        endcase
    end

    assign done      = (state == ST_DONE);
    assign timed_out = (state == ST_TIMEOUT);
    assign pass      = done && (err_count == '0);

`ifdef TEST_SCOREBOARD_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NCHANNELS; c++) begin
                if (mismatch[c])
                    $display("scoreboard: cycle %0d chan %0d mismatch dut=%h exp=%h",
                             cycles, c, dut_msg[c*WIDTH +: WIDTH], head_msg[c]);
            end
            if (state != ST_TIMEOUT && state_nxt == ST_TIMEOUT)
                $display("scoreboard: cycle %0d timeout", cycles);
            if (state != ST_DONE && state_nxt == ST_DONE)
                $display("scoreboard: cycle %0d done, %s (%0d errors)", cycles,
                         (err_next == '0) ? "pass" : "errors seen", err_next);
        end
    end
`endif

endmodule

// File: tb/tb_test_scoreboard.sv
// Purpose: directed bench for test_scoreboard (2 channels, DEPTH=4, TIMEOUT=50) with a
//          reference model; expected error state is queued on each DUT send and checked after.
// Ports: none (top-level bench).
module tb_test_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ref_val, ref_rdy, dut_val, dut_rdy;
    logic [63:0] ref_msg, ref_mask, dut_msg;
    logic        finish, done, timed_out, pass;
    logic [15:0] err_count;
    logic [3:0]  err_chan;
    logic [31:0] err_dut, err_ref;

    always #5 clk = ~clk;

    test_scoreboard #(
        .NCHANNELS (2),
        .WIDTH     (32),
        .DEPTH     (4),
        .TIMEOUT   (50)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ref_val   (ref_val),
        .ref_rdy   (ref_rdy),
        .ref_msg   (ref_msg),
        .ref_mask  (ref_mask),
        .dut_val   (dut_val),
        .dut_rdy   (dut_rdy),
        .dut_msg   (dut_msg),
        .finish    (finish),
        .done      (done),
        .timed_out (timed_out),
        .pass      (pass),
        .err_count (err_count),
        .err_chan  (err_chan),
        .err_dut   (err_dut),
        .err_ref   (err_ref)
    );

    typedef struct {
        int          cnt;
        logic [3:0]  chan;
        logic [31:0] d;
        logic [31:0] r;
    } exp_t;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] mq0[$];
    logic [63:0] mq1[$];
    exp_t        exp_q[$];
    int          m_err;
    logic [3:0]  m_chan;
    logic [31:0] m_dut, m_ref;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        ref_val  = '0;
        dut_val  = '0;
        finish   = 1'b0;
        ref_msg  = '0;
        ref_mask = '0;
        dut_msg  = '0;
        mq0.delete();
        mq1.delete();
        exp_q.delete();
        m_err  = 0;
        m_chan = '0;
        m_dut  = '0;
        m_ref  = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic push(input int ch, input logic [31:0] msg, input logic [31:0] mask);
        chk("ref_rdy_before_push", 32'(ref_rdy[ch]), 32'd1);
        ref_val                = '0;
        ref_val[ch]            = 1'b1;
        ref_msg[ch*32 +: 32]   = msg;
        ref_mask[ch*32 +: 32]  = mask;
        if (ch == 0) mq0.push_back({mask, msg});
        else         mq1.push_back({mask, msg});
        step();
        ref_val = '0;
    endtask

    // Reference behaviour for one DUT message on one channel.
    task automatic model_cmp(input int ch, input logic [31:0] msg);
        logic [63:0] e;
        if (ch == 0) e = mq0.pop_front();
        else         e = mq1.pop_front();
        if (((msg ^ e[31:0]) & ~e[63:32]) != 32'h0) begin
            if (m_err == 0) begin
                m_chan = 4'(ch);
                m_dut  = msg;
                m_ref  = e[31:0];
            end
            if (m_err < 65535) m_err++;
        end
    endtask

    task automatic send(input logic [1:0] chs, input logic [31:0] m0, input logic [31:0] m1);
        exp_t e;
        if (chs[0]) chk("dut_rdy0_before_send", 32'(dut_rdy[0]), 32'd1);
        if (chs[1]) chk("dut_rdy1_before_send", 32'(dut_rdy[1]), 32'd1);
        dut_val = chs;
        dut_msg = {m1, m0};
        if (chs[0]) model_cmp(0, m0);
        if (chs[1]) model_cmp(1, m1);
        exp_q.push_back('{cnt: m_err, chan: m_chan, d: m_dut, r: m_ref});
        step();
        dut_val = '0;
        e = exp_q.pop_front();
        chk("err_count", 32'(err_count), 32'(e.cnt));
        chk("err_chan",  32'(err_chan),  32'(e.chan));
        chk("err_dut",   err_dut,        e.d);
        chk("err_ref",   err_ref,        e.r);
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        step();
        finish = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_ref_rdy",   32'(ref_rdy),   32'h3);
        chk("rst_dut_rdy",   32'(dut_rdy),   32'h0);
        chk("rst_done",      32'(done),      32'h0);
        chk("rst_timed_out", 32'(timed_out), 32'h0);
        chk("rst_pass",      32'(pass),      32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        chk("rst_err_chan",  32'(err_chan),  32'h0);
        chk("rst_err_dut",   err_dut,        32'h0);
        chk("rst_err_ref",   err_ref,        32'h0);

        // Clean in-order run to completion
        do_reset();
        push(0, 32'h1, 32'h0);
        push(0, 32'h2, 32'h0);
        push(0, 32'h3, 32'h0);
        send(2'b01, 32'h1, 32'h0);
        send(2'b01, 32'h2, 32'h0);
        send(2'b01, 32'h3, 32'h0);
        pulse_finish();
        step();
        chk("t1_done",      32'(done),      32'h1);
        chk("t1_pass",      32'(pass),      32'h1);
        chk("t1_err_count", 32'(err_count), 32'h0);

        // Don't-care mask, then a real mismatch in the cared-about bits
        do_reset();
        push(0, 32'hABCD_0000, 32'h0000_FFFF);
        push(0, 32'hABCD_0000, 32'h0000_FFFF);
        send(2'b01, 32'hABCD_1234, 32'h0);
        send(2'b01, 32'hABCE_0000, 32'h0);

        // Full FIFO backpressure and back-to-back pops
        do_reset();
        push(0, 32'h10, 32'h0);
        push(0, 32'h11, 32'h0);
        push(0, 32'h12, 32'h0);
        push(0, 32'h13, 32'h0);
        chk("t3_full_ref_rdy", 32'(ref_rdy[0]), 32'h0);
        chk("t3_other_ref_rdy", 32'(ref_rdy[1]), 32'h1);
        send(2'b01, 32'h10, 32'h0);
        chk("t3_ref_rdy_after_pop", 32'(ref_rdy[0]), 32'h1);
        send(2'b01, 32'h11, 32'h0);
        send(2'b01, 32'h12, 32'h0);
        send(2'b01, 32'h13, 32'h0);
        chk("t3_drained_dut_rdy", 32'(dut_rdy[0]), 32'h0);

        // Simultaneous mismatches, then a later one that must not recapture
        do_reset();
        push(0, 32'h5555_0000, 32'h0);
        push(1, 32'h6666_0000, 32'h0);
        send(2'b11, 32'h5555_0001, 32'h6666_0002);
        push(1, 32'h0000_0007, 32'h0);
        send(2'b10, 32'h0, 32'h0000_0008);

        // Timeout with no finish, then reset clears it
        do_reset();
        repeat (50) step();
        chk("t5_timed_out_pre", 32'(timed_out), 32'h0);
        step();
        chk("t5_timed_out", 32'(timed_out), 32'h1);
        chk("t5_done",      32'(done),      32'h0);
        reset = 1'b1;
        step();
        chk("t5_rst_timed_out", 32'(timed_out), 32'h0);
        chk("t5_rst_ref_rdy",   32'(ref_rdy),   32'h3);
        reset = 1'b0;

        // Finish with entries still queued: drain before done
        do_reset();
        push(0, 32'h21, 32'h0);
        push(0, 32'h22, 32'h0);
        pulse_finish();
        chk("t6_done_in_drain", 32'(done), 32'h0);
        send(2'b01, 32'h21, 32'h0);
        chk("t6_done_one_left", 32'(done), 32'h0);
        send(2'b01, 32'h22, 32'h0);
        step();
        chk("t6_done", 32'(done), 32'h1);
        chk("t6_pass", 32'(pass), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
